// File: rtl/sint_ashr_arb_pkg.sv
// Shared types and helpers for the signed arithmetic-shift-right arbiter.
//   out_state_e : occupancy of the output result buffer
//   ashr_s      : sign-filling shift on a 32-bit sign-extended operand; any shift
//                 amount >= width yields all bits equal to the operand sign bit.
package sint_ashr_arb_pkg;

    typedef enum logic [1:0] {
        OUT_EMPTY = 2'd0,
        OUT_ONE   = 2'd1,   // also the single FULL state of the 1-entry buffer
        OUT_TWO   = 2'd2
    } out_state_e;

    // i0_sext must already be sign-extended from the caller's width, so the low
    // 'width' bits of the result are the correctly filled shift of the operand.
    function automatic logic [31:0] ashr_s(input logic [31:0] i0_sext,
                                           input logic [31:0] i1,
                                           input int unsigned width);
        if (i1 >= width)
            ashr_s = {32{i0_sext[31]}};
        else
            ashr_s = $unsigned($signed(i0_sext) >>> i1[4:0]);
    endfunction

endpackage

// File: rtl/sint_ashr_arbiter_rr.sv
// Round-robin arbiter with an internal priority pointer.
//   i_clk, i_rst : clock, synchronous active-high reset (pointer -> 0)
//   i_req        : request vector
//   i_advance    : a grant was taken this cycle; pointer moves past the winner
//   o_gnt        : one-hot candidate (zero when no request)
//   o_idx        : candidate index
//   o_found      : at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_found
);

    logic [ID_W-1:0] r_ptr;

    // Scan upward from the pointer, wrapping; first set request wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_found && i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
                o_found = 1'b1;
                o_idx   = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
        o_gnt = o_found ? (NUM_REQ'(1) << o_idx) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ptr <= '0;
        else if (i_advance)
            r_ptr <= (int'(o_idx) == NUM_REQ - 1) ? '0 : o_idx + 1'b1;
    end

endmodule

// File: rtl/sint_ashr_arbiter.sv
// Shares one signed arithmetic-shift-right unit between NUM_REQ requesters.
// Round-robin grant, valid/ready on both sides, 1-cycle registered result
// tagged with the requester index.
//   CLK, RESET          : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_I0 / req_I1     : packed signed operand / unsigned shift amount, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/ready    : result handshake
//   resp_O / resp_id    : shifted result and producing requester index
// Build option ASHR_ARB_SKID_EN: 2-entry output skid buffer with a registered
// accept (no resp_ready -> req_ready path). Undefined: 1-entry buffer where a
// draining result can be replaced in the same cycle.
module sint_ashr_arbiter
    import sint_ashr_arb_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_I0,
    input  logic [NUM_REQ*WIDTH-1:0] req_I1,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_O,
    output logic [ID_W-1:0]          resp_id
);

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_found;
    logic               w_accept;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_i0;
    logic [WIDTH-1:0]   w_i1;
    logic [WIDTH-1:0]   w_shift;
    logic               w_ld_head;

    out_state_e         r_state;
    out_state_e         w_state_nx;
    logic [WIDTH-1:0]   r_o;
    logic [ID_W-1:0]    r_id;

`ifdef ASHR_ARB_SKID_EN
    logic               w_ld_tail;
    logic               w_pop_tail;
    logic [WIDTH-1:0]   r_o_tail;
    logic [ID_W-1:0]    r_id_tail;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_req     (req_valid),
        .i_advance (w_xfer),
        .o_gnt     (w_gnt),
        .o_idx     (w_gnt_idx),
        .o_found   (w_found)
    );

`ifdef ASHR_ARB_SKID_EN
    assign w_accept = (r_state != OUT_TWO);
`else
    // Full throughput: a buffered result leaving this cycle frees the slot.
    assign w_accept = (r_state == OUT_EMPTY) | resp_ready;
`endif

    assign req_ready = w_gnt & {NUM_REQ{w_accept & ~RESET}};
    assign w_xfer    = w_found & w_accept & ~RESET;

    assign w_i0    = req_I0[int'(w_gnt_idx)*WIDTH +: WIDTH];
    assign w_i1    = req_I1[int'(w_gnt_idx)*WIDTH +: WIDTH];
    assign w_shift = WIDTH'(ashr_s(32'(signed'(w_i0)), 32'(w_i1), WIDTH));

    always_ff @(posedge CLK) begin
        if (RESET)
            r_state <= OUT_EMPTY;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_ld_head  = 1'b0;
`ifdef ASHR_ARB_SKID_EN
        w_ld_tail  = 1'b0;
        w_pop_tail = 1'b0;
        case (r_state)
            OUT_EMPTY: begin
                if (w_xfer) begin
                    w_ld_head  = 1'b1;
                    w_state_nx = OUT_ONE;
                end
            end
            OUT_ONE: begin
                if (w_xfer && resp_ready) begin
                    w_ld_head = 1'b1;
                end else if (w_xfer) begin
                    w_ld_tail  = 1'b1;
                    w_state_nx = OUT_TWO;
                end else if (resp_ready) begin
                    w_state_nx = OUT_EMPTY;
                end
            end
            OUT_TWO: begin
                if (resp_ready) begin
                    w_pop_tail = 1'b1;
                    w_state_nx = OUT_ONE;
                end
            end
            default: w_state_nx = OUT_EMPTY;
        endcase
`else
        case (r_state)
            OUT_EMPTY: begin
                if (w_xfer) begin
                    w_ld_head  = 1'b1;
                    w_state_nx = OUT_ONE;
                end
            end
            OUT_ONE: begin
                if (w_xfer)
                    w_ld_head = 1'b1;
                else if (resp_ready)
                    w_state_nx = OUT_EMPTY;
            end
            default: w_state_nx = OUT_EMPTY;
        endcase
`endif
    end

    // Data registers only move on a load, so resp_O/resp_id hold while
    // stalled and keep the last value once the buffer empties.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_o  <= '0;
            r_id <= '0;
`ifdef ASHR_ARB_SKID_EN
            r_o_tail  <= '0;
            r_id_tail <= '0;
`endif
        end else begin
            if (w_ld_head) begin
                r_o  <= w_shift;
                r_id <= w_gnt_idx;
            end
`ifdef ASHR_ARB_SKID_EN
            else if (w_pop_tail) begin
                r_o  <= r_o_tail;
                r_id <= r_id_tail;
            end
            if (w_ld_tail) begin
                r_o_tail  <= w_shift;
                r_id_tail <= w_gnt_idx;
            end
`endif
        end
    end

    assign resp_valid = (r_state != OUT_EMPTY);
    assign resp_O     = r_o;
    assign resp_id    = r_id;

endmodule

// File: tb/tb_sint_ashr_arbiter.sv
module tb_sint_ashr_arbiter;

    localparam int W   = 3;
    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef ASHR_ARB_SKID_EN
    localparam int EXP_STALL_XFERS = 2;
`else
    localparam int EXP_STALL_XFERS = 1;
`endif

    logic           CLK = 1'b0;
    logic           RESET;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_I0;
    logic [N*W-1:0] req_I1;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_O;
    logic [IDW-1:0] resp_id;

    sint_ashr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_I0     (req_I0),
        .req_I1     (req_I1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_O     (resp_O),
        .resp_id    (resp_id)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-by-bit reference: bit b takes operand bit b+sh, or the sign past the top.
    function automatic logic [W-1:0] ref_ashr(input logic [W-1:0] a, input logic [W-1:0] sh);
        logic [W-1:0] r;
        for (int b = 0; b < W; b++) begin
            if (b + int'(sh) >= W)
                r[b] = a[W-1];
            else
                r[b] = a[b + int'(sh)];
        end
        return r;
    endfunction

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   o;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   wait_cnt[N];
    bit   got_xfer[N];

    // Scoreboard: every accepted request produces exactly one response, in order.
    always @(negedge CLK) begin
        if (RESET) begin
            sb_q.delete();
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else begin
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_resp_O", 32'(resp_O), 32'(sb_e.o));
                    check("sb_resp_id", 32'(resp_id), 32'(sb_e.id));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back({IDW'(i), ref_ashr(req_I0[i*W +: W], req_I1[i*W +: W])});
                    got_xfer[i] = 1'b1;
                    check("rr_wait_bound", 32'(wait_cnt[i] <= N - 1), 32'd1);
                    wait_cnt[i] = 0;
                end else if (req_valid[i] && |(req_valid & req_ready)) begin
                    wait_cnt[i]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        tick();
        RESET     = 1'b1;
        req_valid = '0;
        tick();
        RESET     = 1'b0;
    endtask

    task automatic single_req0(input logic [W-1:0] i0, input logic [W-1:0] i1,
                               input logic [W-1:0] exp_o);
        tick();
        req_valid  = 4'b0001;
        req_I0[W-1:0] = i0;
        req_I1[W-1:0] = i1;
        resp_ready = 1'b1;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        check("single_valid", 32'(resp_valid), 32'd1);
        check("single_O", 32'(resp_O), 32'(exp_o));
        check("single_id", 32'(resp_id), 32'd0);
    endtask

    int   xfers;
    int   drain;

    initial begin
        RESET      = 1'b1;
        req_valid  = '1;
        req_I0     = '0;
        req_I1     = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) got_xfer[i] = 1'b0;

        // Reset held two cycles with every requester asking.
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_valid", 32'(resp_valid), 32'd0);
            check("rst_O", 32'(resp_O), 32'd0);
            check("rst_id", 32'(resp_id), 32'd0);
        end
        RESET     = 1'b0;
        req_valid = '0;

        // Single requester shift cases.
        single_req0(3'b100, 3'd1, 3'b110);
        single_req0(3'b100, 3'd7, 3'b111);
        single_req0(3'b011, 3'd5, 3'b000);
        single_req0(3'b101, 3'd2, 3'b111);
        single_req0(3'b011, 3'd1, 3'b001);

        // All four valid: rotation 0,1,2,3,0 at one result per cycle.
        reset_dut();
        tick();
        req_I0     = {3'b011, 3'b101, 3'b110, 3'b100};
        req_I1     = {3'd1,   3'd2,   3'd0,   3'd3};
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        #1;
        check("rr_grant0", 32'(req_ready), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            check("rr_resp_valid", 32'(resp_valid), 32'd1);
            check("rr_resp_id", 32'(resp_id), 32'((k - 1) % 4));
        end
        tick();
        req_valid = '0;

        // Consumer stalled five cycles with requester 2 asking.
        reset_dut();
        tick();
        req_valid  = 4'b0100;
        req_I0     = '0;
        req_I1     = '0;
        req_I0[2*W +: W] = 3'b101;
        req_I1[2*W +: W] = 3'd1;
        resp_ready = 1'b0;
        #1;
        xfers = req_ready[2] ? 1 : 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_O_held", 32'(resp_O), 32'(3'b110));
            check("stall_id_held", 32'(resp_id), 32'd2);
            if (req_ready[2]) xfers++;
        end
        check("stall_xfers", 32'(xfers), 32'(EXP_STALL_XFERS));
        check("stall_ready_low", 32'(req_ready), 32'd0);
        tick();
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        #1;
        check("stall_drained_q", 32'(sb_q.size()), 32'd0);
        check("stall_drained_valid", 32'(resp_valid), 32'd0);

        // Reset while a result is buffered; pointer currently past requester 2.
        tick();
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        tick();
        req_valid = '0;
        #1;
        check("midrst_pre_valid", 32'(resp_valid), 32'd1);
        tick();
        RESET     = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("midrst_ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        #1;
        check("midrst_valid_cleared", 32'(resp_valid), 32'd0);
        RESET = 1'b0;
        #1;
        check("midrst_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid  = '0;
        resp_ready = 1'b1;
        #1;
        check("midrst_resp_id", 32'(resp_id), 32'd0);
        tick();

        // Randomised traffic; requests stay up until accepted.
        for (int i = 0; i < N; i++) got_xfer[i] = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || got_xfer[i]) begin
                    got_xfer[i] = 1'b0;
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_I0[i*W +: W] = W'($urandom);
                    req_I1[i*W +: W] = W'($urandom);
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        req_valid  = '0;
        resp_ready = 1'b1;
        drain = 0;
        while (sb_q.size() != 0 && drain < 10) begin
            tick();
            drain++;
        end
        tick();
        #1;
        check("rand_drained_q", 32'(sb_q.size()), 32'd0);
        check("rand_drained_valid", 32'(resp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
